// File: rtl/cond_unit_if.sv
// Decoder/datapath-facing bundle of the conditional-execution unit.
// The decoder drives the request side; the unit returns gated enables and state.
interface cond_unit_if #(
  parameter int IT_MAX = 4,
  parameter int SW     = $clog2(IT_MAX + 1)
);
  logic              en;
  logic [3:0]        cond;
  logic [3:0]        alu_flags;
  logic [1:0]        flag_w;
  logic              pcs;
  logic              reg_w;
  logic              mem_w;
  logic              it_start;
  logic [3:0]        it_cond;
  logic [SW-1:0]     it_len;
  logic [IT_MAX-1:0] it_te;
  logic              cond_ex;
  logic              pcs_o;
  logic              reg_w_o;
  logic              mem_w_o;
  logic [3:0]        flags_q;
  logic              it_active;
  logic [SW-1:0]     it_slot;

  modport master (
    output en, cond, alu_flags, flag_w, pcs, reg_w, mem_w,
           it_start, it_cond, it_len, it_te,
    input  cond_ex, pcs_o, reg_w_o, mem_w_o, flags_q, it_active, it_slot
  );

  modport slave (
    input  en, cond, alu_flags, flag_w, pcs, reg_w, mem_w,
           it_start, it_cond, it_len, it_te,
    output cond_ex, pcs_o, reg_w_o, mem_w_o, flags_q, it_active, it_slot
  );
endinterface

// File: rtl/cond_unit.sv
// NZCV flag register, condition evaluation and write-enable gating, with an
// IT-block sequencer that predicates up to IT_MAX following instructions.
module cond_unit #(
  parameter int         IT_MAX      = 4,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  cond_unit_if.slave  bus
);
  localparam int SW = $clog2(IT_MAX + 1);

  typedef enum logic {IDLE, IT_ACTIVE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        flags_q, flags_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [SW-1:0]     len_q, len_d;
  logic [3:0]        it_cond_q, it_cond_d;
  logic [IT_MAX-1:0] it_te_q, it_te_d;

  logic       len_ok, marker, te_bit, cond_ex;
  logic [3:0] eff_cond;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cf;
      4'h3:    cond_pass = !cf;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cf & !z;
      4'h9:    cond_pass = !cf | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign len_ok = (bus.it_len != '0) && (bus.it_len <= SW'(IT_MAX));
  // A valid marker only ever counts from IDLE; inside a block it is just a slot.
  assign marker = (state_q == IDLE) && bus.it_start && len_ok;

  always_comb begin
    te_bit = 1'b0;
    for (int i = 0; i < IT_MAX; i++)
      if (slot_q == SW'(i)) te_bit = it_te_q[i];
  end

  assign eff_cond = (state_q == IT_ACTIVE) ? (te_bit ? it_cond_q : (it_cond_q ^ 4'b0001))
                                           : bus.cond;
  assign cond_ex  = !marker && cond_pass(eff_cond, flags_q);

  assign bus.cond_ex   = cond_ex;
  assign bus.pcs_o     = bus.pcs   & cond_ex;
  assign bus.reg_w_o   = bus.reg_w & cond_ex;
  assign bus.mem_w_o   = bus.mem_w & cond_ex;
  assign bus.flags_q   = flags_q;
  assign bus.it_active = (state_q == IT_ACTIVE);
  assign bus.it_slot   = slot_q;

  always_comb begin
    flags_d = flags_q;
    if (bus.en && cond_ex) begin
      if (bus.flag_w[1]) flags_d[3:2] = bus.alu_flags[3:2];
      if (bus.flag_w[0]) flags_d[1:0] = bus.alu_flags[1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    len_d     = len_q;
    it_cond_d = it_cond_q;
    it_te_d   = it_te_q;
    if (bus.en) begin
      case (state_q)
        IDLE: if (marker) begin
          state_d   = IT_ACTIVE;
          slot_d    = '0;
          len_d     = bus.it_len;
          it_cond_d = bus.it_cond;
          it_te_d   = bus.it_te | IT_MAX'(1);
        end
        default: begin
          // Failed slots still consume their position in the block.
          if (slot_q == len_q - SW'(1)) begin
            state_d = IDLE;
            slot_d  = '0;
          end else begin
            slot_d  = slot_q + SW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      flags_q   <= RESET_FLAGS;
      slot_q    <= '0;
      len_q     <= '0;
      it_cond_q <= '0;
      it_te_q   <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      slot_q    <= slot_d;
      len_q     <= len_d;
      it_cond_q <= it_cond_d;
      it_te_q   <= it_te_d;
    end
  end
endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: expected output snapshots are queued as
// stimulus is applied and popped when the DUT outputs are sampled.
module tb_cond_unit;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  cond_unit_if #(.IT_MAX(4)) bus ();

  cond_unit #(.IT_MAX(4), .RESET_FLAGS(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {cond_ex, pcs_o, reg_w_o, mem_w_o, flags_q, it_active, it_slot}
  logic [12:0] obs;
  assign obs = {bus.cond_ex, bus.pcs_o, bus.reg_w_o, bus.mem_w_o,
                bus.flags_q, bus.it_active, bus.it_slot};

  logic [12:0] exp_q[$];
  logic [12:0] e;

  function automatic logic [12:0] mk(input logic cex, input logic [3:0] fl,
                                     input logic act, input logic [SW-1:0] slot);
    mk = {cex, cex, cex, cex, fl, act, slot};
  endfunction

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    ref_cond = c[0] ? !base : base;
  endfunction

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.cond = 4'hF; bus.alu_flags = 4'h0; bus.flag_w = 2'b00;
    bus.pcs = 1'b1; bus.reg_w = 1'b1; bus.mem_w = 1'b1;
    bus.it_start = 1'b0; bus.it_cond = 4'h0; bus.it_len = '0; bus.it_te = 4'h0;
    exp_q.push_back(mk(1'b0, 4'b0000, 1'b0, 3'd0));
    #12;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset: got %b want %b", obs, e); end
    rst = 1'b0;
    edge1();
  endtask

  task automatic test_cond_table();
    for (int f = 0; f < 16; f++) begin
      bus.cond = 4'hE; bus.flag_w = 2'b11; bus.alu_flags = 4'(f); bus.en = 1'b1;
      edge1();
      bus.en = 1'b0;
      for (int c = 0; c < 16; c++)
        exp_q.push_back(mk(ref_cond(4'(c), 4'(f)), 4'(f), 1'b0, 3'd0));
      for (int c = 0; c < 16; c++) begin
        bus.cond = 4'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (obs !== e)
          begin errors++; $display("FAIL cond_table c=%0h f=%b: got %b want %b", c, f[3:0], obs, e); end
      end
    end
  endtask

  task automatic test_flag_update();
    bus.cond = 4'hE; bus.flag_w = 2'b11; bus.alu_flags = 4'b0000; bus.en = 1'b1;
    edge1();
    bus.alu_flags = 4'b0100; #1;
    exp_q.push_back(mk(1'b1, 4'b0000, 1'b0, 3'd0));
    exp_q.push_back(mk(1'b1, 4'b0100, 1'b0, 3'd0));
    exp_q.push_back(mk(1'b1, 4'b0111, 1'b0, 3'd0));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL flag_pre: got %b want %b", obs, e); end
    edge1();
    bus.cond = 4'h0; bus.flag_w = 2'b00; bus.en = 1'b0; #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL flag_eq_next: got %b want %b", obs, e); end
    bus.cond = 4'hE; bus.flag_w = 2'b01; bus.alu_flags = 4'b1011; bus.en = 1'b1;
    edge1();
    bus.en = 1'b0; #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL flag_cv_only: got %b want %b", obs, e); end
  endtask

  task automatic test_fail_gating();
    bus.cond = 4'h1; bus.flag_w = 2'b11; bus.alu_flags = 4'b1000; bus.en = 1'b1; #1;
    exp_q.push_back(mk(1'b0, 4'b0111, 1'b0, 3'd0));
    exp_q.push_back(mk(1'b0, 4'b0111, 1'b0, 3'd0));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL gate_off: got %b want %b", obs, e); end
    edge1();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL gate_flags_hold: got %b want %b", obs, e); end
  endtask

  task automatic test_it();
    bus.en = 1'b1; bus.cond = 4'hE; bus.flag_w = 2'b11; bus.alu_flags = 4'b0000;
    bus.it_start = 1'b1; bus.it_cond = 4'h0; bus.it_len = 3'd3; bus.it_te = 4'b0101;
    exp_q.push_back(mk(1'b0, 4'b0111, 1'b0, 3'd0));
    exp_q.push_back(mk(1'b1, 4'b0111, 1'b1, 3'd0));
    exp_q.push_back(mk(1'b0, 4'b0111, 1'b1, 3'd1));
    exp_q.push_back(mk(1'b1, 4'b0111, 1'b1, 3'd2));
    exp_q.push_back(mk(1'b0, 4'b0111, 1'b0, 3'd0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL it_marker: got %b want %b", obs, e); end
    edge1();
    bus.it_start = 1'b0; bus.cond = 4'hF; bus.flag_w = 2'b00;
    for (int s = 0; s < 4; s++) begin
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL it_slot%0d: got %b want %b", s, obs, e); end
      edge1();
    end
  endtask

  task automatic test_stall();
    bus.en = 1'b1; bus.cond = 4'h0; bus.flag_w = 2'b00;
    bus.it_start = 1'b1; bus.it_cond = 4'hE; bus.it_len = 3'd3; bus.it_te = 4'b0010;
    exp_q.push_back(mk(1'b1, 4'b0111, 1'b1, 3'd0));
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(1'b1, 4'b0000, 1'b1, 3'd1));
    exp_q.push_back(mk(1'b0, 4'b0000, 1'b1, 3'd2));
    exp_q.push_back(mk(1'b0, 4'b0000, 1'b0, 3'd0));
    edge1();
    bus.it_start = 1'b0; bus.flag_w = 2'b11; bus.alu_flags = 4'b0000; #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL stall_slot0: got %b want %b", obs, e); end
    edge1();
    bus.en = 1'b0; bus.alu_flags = 4'b1111; #1;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL stall_hold%0d: got %b want %b", k, obs, e); end
      if (k < 2) edge1();
    end
    bus.en = 1'b1; bus.flag_w = 2'b00;
    edge1();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL stall_slot2_never: got %b want %b", obs, e); end
    edge1();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL stall_exit: got %b want %b", obs, e); end
  endtask

  task automatic test_reset_mid_it();
    bus.en = 1'b1; bus.cond = 4'hE; bus.flag_w = 2'b11; bus.alu_flags = 4'b1111;
    edge1();
    bus.flag_w = 2'b00; bus.cond = 4'hF;
    bus.it_start = 1'b1; bus.it_cond = 4'hE; bus.it_len = 3'd3; bus.it_te = 4'b0111;
    edge1();
    bus.it_start = 1'b0;
    edge1();
    exp_q.push_back(mk(1'b1, 4'b1111, 1'b1, 3'd1));
    exp_q.push_back(mk(1'b0, 4'b0000, 1'b0, 3'd0));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_mid_pre: got %b want %b", obs, e); end
    #2; rst = 1'b1; #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_mid_async: got %b want %b", obs, e); end
    #1; rst = 1'b0;
    edge1();
  endtask

  task automatic test_invalid_it();
    bus.en = 1'b1; bus.cond = 4'hE; bus.flag_w = 2'b11; bus.alu_flags = 4'b1001;
    bus.it_start = 1'b1; bus.it_cond = 4'h0; bus.it_len = 3'd0; bus.it_te = 4'b0000;
    exp_q.push_back(mk(1'b1, 4'b0000, 1'b0, 3'd0));
    exp_q.push_back(mk(1'b1, 4'b1001, 1'b0, 3'd0));
    exp_q.push_back(mk(1'b1, 4'b1001, 1'b0, 3'd0));
    exp_q.push_back(mk(1'b1, 4'b0110, 1'b0, 3'd0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL inv_len0_pre: got %b want %b", obs, e); end
    edge1();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL inv_len0_post: got %b want %b", obs, e); end
    bus.it_len = 3'd5; bus.alu_flags = 4'b0110; #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL inv_len5_pre: got %b want %b", obs, e); end
    edge1();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL inv_len5_post: got %b want %b", obs, e); end
    bus.it_start = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.en = 1'b1; bus.cond = 4'hF; bus.flag_w = 2'b00;
    bus.it_start = 1'b1; bus.it_cond = 4'hE; bus.it_len = 3'd1; bus.it_te = 4'b0001;
    exp_q.push_back(mk(1'b0, 4'b0110, 1'b0, 3'd0));
    exp_q.push_back(mk(1'b1, 4'b0110, 1'b1, 3'd0));
    exp_q.push_back(mk(1'b0, 4'b0110, 1'b0, 3'd0));
    exp_q.push_back(mk(1'b0, 4'b0110, 1'b1, 3'd0));
    exp_q.push_back(mk(1'b1, 4'b0110, 1'b1, 3'd1));
    exp_q.push_back(mk(1'b0, 4'b0110, 1'b0, 3'd0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL b2b_marker1: got %b want %b", obs, e); end
    edge1();
    bus.it_cond = 4'hF; bus.it_len = 3'd2; #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL b2b_start_ignored: got %b want %b", obs, e); end
    edge1();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL b2b_marker2: got %b want %b", obs, e); end
    edge1();
    bus.it_start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b_step%0d: got %b want %b", s, obs, e); end
      edge1();
    end
  endtask

  initial begin
    test_reset();
    test_cond_table();
    test_flag_update();
    test_fail_gating();
    test_it();
    test_stall();
    test_reset_mid_it();
    test_invalid_it();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d want 0 left", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
